// File: rtl/wb_retire_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : wb_retire_unit                                            |
// | Description : MEM/WB write-back mux, register-file write port, one-cycle |
// |               write bypass and halt/drain/halted freeze control.        |
// |               Optional retired-instruction counter: WB_PERF_CNT_EN.     |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module wb_retire_unit #(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 4,
  parameter int DRAIN_CYCLES = 2
`ifdef WB_PERF_CNT_EN
  ,parameter int CNT_W       = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              PCtoReg,
  input  logic              Halt,
  input  logic              is_noop,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] dmem_data,
  input  logic [DATA_W-1:0] pc_data,
  input  logic [REG_AW-1:0] DstReg,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_addr,
  output logic [DATA_W-1:0] byp_data,
  output logic              freeze,
  output logic              halted
`ifdef WB_PERF_CNT_EN
  ,output logic [CNT_W-1:0] retired_cnt
`endif
);

  localparam logic [1:0] c_run        = 2'd0;
  localparam logic [1:0] c_drain      = 2'd1;
  localparam logic [1:0] c_halted     = 2'd2;
  localparam logic [2:0] c_drain_load = 3'(DRAIN_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              v;
  logic              byp_valid_q;
  logic [REG_AW-1:0] byp_addr_q;
  logic [DATA_W-1:0] byp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_run;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // halted rises DRAIN_CYCLES cycles after the Halt cycle, so a single-cycle drain skips DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_run: begin
        if (v && Halt) begin
          cnt_d   = c_drain_load;
          state_d = (DRAIN_CYCLES == 1) ? c_halted : c_drain;
        end
      end
      c_drain: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = c_halted;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      c_halted: begin
        state_d = c_halted;
      end
      default: begin
        state_d = c_run;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    v        = ~is_noop & (state_q == c_run);
    freeze   = (state_q != c_run);
    halted   = (state_q == c_halted);
    rf_waddr = DstReg;
    rf_wdata = PCtoReg ? pc_data : (MemtoReg ? dmem_data : reg_data);
    rf_wen   = v & RegWrite & (DstReg != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= rf_wen;
      byp_addr_q  <= rf_waddr;
      byp_data_q  <= rf_wdata;
    end
  end

  assign byp_valid = byp_valid_q;
  assign byp_addr  = byp_addr_q;
  assign byp_data  = byp_data_q;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt_q <= '0;
    end else if (v && (retired_cnt_q != '1)) begin
      retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/wb_retire_unit.md
Name: wb_retire_unit

Overview:
- Write-back and retirement end of the MEM/WB interface.
- Consumes the registered MEM/WB outputs, selects the write-back value and drives the register-file write port.
- Keeps a one-cycle write-history bypass for the decode stage and runs the halt/drain state machine that freezes the core.
- Sits between the MEM/WB pipeline register and the register file / top-level `hlt` output.

Parameters:
- DATA_W, 16, data path width.
- REG_AW, 4, register address width (16 architectural registers; R0 reads as zero).
- DRAIN_CYCLES, 2, cycles spent in DRAIN after Halt retires before `halted` asserts (1..7).
- CNT_W, 32, retired-instruction counter width (only with WB_PERF_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RegWrite  in  1  MEM/WB write-back enable.
- MemtoReg  in  1  select dmem data.
- PCtoReg  in  1  select PC value (PCS); has priority over MemtoReg.
- Halt  in  1  HLT instruction in write-back.
- is_noop  in  1  bubble marker; suppresses all effects.
- reg_data  in  DATA_W  ALU result.
- dmem_data  in  DATA_W  load data.
- pc_data  in  DATA_W  PC value for PCS.
- DstReg  in  REG_AW  destination register.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  REG_AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- byp_valid  out  1  previous-cycle write is valid.
- byp_addr  out  REG_AW  previous-cycle write address.
- byp_data  out  DATA_W  previous-cycle write data.
- freeze  out  1  stall fetch and decode; high in DRAIN and HALTED.
- halted  out  1  core halted; top-level `hlt`.
- retired_cnt  out  CNT_W  retired instruction count (WB_PERF_CNT_EN only).

Behaviour:
- Effective valid: `v = ~is_noop & (state==RUN)`.
- Write-back data mux, combinational: `rf_wdata = PCtoReg ? pc_data : (MemtoReg ? dmem_data : reg_data)`.
- `rf_waddr = DstReg`.
- `rf_wen = v & RegWrite & (DstReg != 0)`. Writes to R0 are dropped.
- Bypass registers (byp_*) capture rf_wen, rf_waddr and rf_wdata every cycle.
  - They present the previous cycle's write so decode can cover the register-file read-during-write hazard.
  - byp_addr and byp_data are undefined when byp_valid is 0.
  - On reset, all byp_* outputs are 0.
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- RUN -> DRAIN when `v & Halt`.
  - If RegWrite is also set in that cycle, the write still occurs.
  - The drain counter loads DRAIN_CYCLES-1.
- DRAIN: counter decrements each cycle. Go to HALTED when the counter is 0 at a clock edge.
  - Result: `halted` rises exactly DRAIN_CYCLES cycles after the Halt cycle.
- In DRAIN and HALTED:
  - rf_wen is forced to 0; younger instructions are squashed.
  - Halt inputs are ignored.
- HALTED is sticky; only rst leaves it.
- Outputs:
  - `freeze = (state != RUN)`, combinational from state.
  - `halted = (state == HALTED)`.
- rst asserted mid-drain returns the FSM to RUN immediately (asynchronous) and clears the counter, bypass registers and retired_cnt.
- Halt with is_noop=1 is a bubble: no transition.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - retired_cnt increments by 1 each cycle with `v` high, including the HLT instruction itself.
  - Saturates at all-ones; no wrap.
  - Reset value 0.
- Undefined:
  - retired_cnt port is absent.
  - No counter logic is synthesized.

Test Plan:
- ALU write: RegWrite=1, DstReg=3, reg_data=0x1234, Mem/PC selects 0 -> rf_wen=1, waddr=3, wdata=0x1234; next cycle byp_valid=1, byp_addr=3, byp_data=0x1234.
- Mux priority: PCtoReg=1, MemtoReg=1, pc_data=0x0042, dmem_data=0xBEEF -> wdata=0x0042; with PCtoReg=0 -> wdata=0xBEEF.
- Suppression:
  - DstReg=0, RegWrite=1 -> rf_wen=0, next-cycle byp_valid=0.
  - is_noop=1, RegWrite=1, DstReg=5 -> rf_wen=0.
  - is_noop=1, Halt=1 -> state stays RUN.
- Halt drain with DRAIN_CYCLES=2:
  - Halt at cycle N -> freeze=1 from N+1, halted=1 from N+2.
  - RegWrite=1 to R7 at N+1 -> rf_wen=0.
  - halted stays 1 for 20 further cycles.
- Reset in DRAIN: assert rst asynchronously at N+1 -> freeze=0, halted=0, byp_valid=0 before the next clock edge; normal write-back resumes after rst deasserts.
- With WB_PERF_CNT_EN: 5 valid instructions, 3 bubbles, then HLT -> retired_cnt=6. Preload count to all-ones minus 1, retire 3 -> count holds all-ones.
